uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Host-side byte FIFO feeding a UART transmitter. Host writes
//               are queued in a DEPTH-entry circular buffer. A small launch
//               FSM pops one byte at a time, pulses tx_valid for one cycle,
//               waits for the transmitter to raise Busy, then waits for Busy
//               to fall before the next launch. If Busy never rises within
//               4 cycles, the byte is abandoned and launch_lost pulses.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               wr_en, wr_data    - host write request and byte
//               full, empty       - occupancy flags (count == DEPTH / 0)
//               count             - stored entries, 0..DEPTH
//               overflow          - sticky, set when a write is dropped
//               tx_data, tx_valid - byte and launch pulse to transmitter
//               tx_busy           - transmitter Busy
//               launch_lost       - one-cycle pulse on launch timeout
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_busy,
    output logic                  launch_lost
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(DEPTH);
    localparam logic [1:0]         c_TIMER_MAX  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [1:0]            r_timer;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic                  r_launch_lost;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_pop;
    logic w_timeout;

    // Flags come from the registered count, so a pop in the same cycle never
    // frees room for a write, and a write into an empty FIFO is not visible
    // to the launch logic until the next cycle.
    assign w_full   = (r_count == c_FULL_COUNT);
    assign w_empty  = (r_count == '0);
    assign w_accept = wr_en && !w_full;

    // ------------------------------------------------------------------
    // Launch FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Launch FSM: next state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_timer == c_TIMER_MAX) begin
                    // Transmitter never acknowledged; the byte is dropped.
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array (not reset; contents are don't-care until written)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, launch datapath and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_timer       <= '0;
            r_overflow    <= 1'b0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_launch_lost <= 1'b0;
        end else begin
            r_tx_valid    <= w_pop;
            r_launch_lost <= w_timeout;

            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end

            // DEPTH is a power of two, so natural wrap gives modulo-DEPTH.
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end

            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + c_PTR_W'(1);
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Timer restarts at each launch and only advances while waiting
            // for the transmitter to acknowledge.
            if (w_pop) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT_BUSY) begin
                r_timer <= r_timer + 2'd1;
            end
        end
    end

    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign launch_lost = r_launch_lost;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A queue-based reference
//               model predicts every output each cycle; a configurable
//               transmitter Busy model answers launches. Directed scenarios
//               with random data are followed by a randomized soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          tx_busy = 1'b0;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          launch_lost;

    uart_tx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_busy     (tx_busy),
        .launch_lost (launch_lost)
    );

    always #5 clk = ~clk;

    // Counters
    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of stored bytes plus the launch phase
    // (0 = ready, 1 = awaiting Busy, 2 = transmitter busy).
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_txd     = '0;
    bit            m_txv     = 1'b0;
    bit            m_lost    = 1'b0;
    bit            m_ov      = 1'b0;
    int            m_phase   = 0;
    int            m_launch  = 0;
    int            cyc       = 0;

    // Observation record
    logic [DW-1:0] got[$];
    logic [DW-1:0] sent[$];
    int            t_valid   = -100;
    int            t_lost    = -100;
    int            t_wr      = 0;
    int            lost_cnt  = 0;

    // Transmitter Busy model: Busy rises bm_d cycles after tx_valid, lasts bm_l
    bit bm_en   = 1'b0;
    bit bm_rand = 1'b0;
    int bm_d    = 2;
    int bm_l    = 3;
    int bm_cnt  = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_update();
        bit was_full;
        bit was_empty;
        cyc++;
        if (rst) begin
            q.delete();
            m_ov = 1'b0; m_phase = 0; m_txd = '0; m_txv = 1'b0; m_lost = 1'b0;
            return;
        end
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        m_txv  = 1'b0;
        m_lost = 1'b0;
        case (m_phase)
            0: if (!was_empty && !tx_busy) begin
                   m_txd = q.pop_front(); m_txv = 1'b1; m_phase = 1; m_launch = cyc;
               end
            1: if (tx_busy) m_phase = 2;
               else if (cyc - m_launch == 4) begin m_phase = 0; m_lost = 1'b1; end
            2: if (!tx_busy) m_phase = 0;
            default: m_phase = 0;
        endcase
        if (wr_en) begin
            if (was_full) m_ov = 1'b1;
            else          q.push_back(wr_data);
        end
    endtask

    task automatic check_outputs();
        chk("tx_valid",    tx_valid,    m_txv);
        chk("tx_data",     tx_data,     m_txd);
        chk("count",       count,       q.size());
        chk("full",        full,        q.size() == DEPTH);
        chk("empty",       empty,       q.size() == 0);
        chk("overflow",    overflow,    m_ov);
        chk("launch_lost", launch_lost, m_lost);
        if (tx_valid === 1'b1) begin got.push_back(tx_data); t_valid = cyc; end
        if (launch_lost === 1'b1) begin t_lost = cyc; lost_cnt++; end
    endtask

    task automatic busy_model();
        if (!bm_en) return;
        if (tx_valid === 1'b1) begin
            bm_cnt = 0;
            if (bm_rand) begin bm_d = $urandom_range(0, 5); bm_l = $urandom_range(1, 6); end
        end else if (bm_cnt >= 0) begin
            bm_cnt++;
        end
        tx_busy = (bm_cnt >= 0) && (bm_cnt + 1 >= bm_d) && (bm_cnt + 1 < bm_d + bm_l);
        if (bm_cnt >= 0 && bm_cnt + 1 >= bm_d + bm_l) bm_cnt = -1;
    endtask

    // One clock: model sees the inputs held across the edge, outputs checked
    // 1 time unit later, then the Busy model chooses the next input.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
        busy_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; bm_cnt = -1;
        ticks(2);
        rst = 1'b0;
        got.delete(); lost_cnt = 0;
    endtask

    task automatic write(input logic [DW-1:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] b0, b1, b2, bx;

        // ---- Reset state ----
        do_reset();
        chk("rst_empty", empty, 1'b1);
        chk("rst_full",  full,  1'b0);
        chk("rst_count", count, 0);

        // ---- Single byte with Busy 2 cycles after launch for 10 cycles ----
        bm_en = 1'b1; bm_d = 2; bm_l = 10; tx_busy = 1'b0;
        t_wr = cyc;
        write(8'hA5);
        ticks(20);
        chk("single_latency", t_valid - t_wr, 2);
        chk("single_nbytes",  got.size(), 1);
        chk("single_data",    got[0], 8'hA5);
        chk("single_count",   count, 0);

        // ---- Fill and overflow with Busy held high ----
        do_reset();
        bm_en = 1'b0; tx_busy = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            write(DW'(i));
            if (i == 8) begin
                chk("fill_full8",  full, 1'b1);
                chk("fill_count8", count, 8);
                chk("fill_ov8",    overflow, 1'b0);
            end
        end
        chk("ovf_flag",  overflow, 1'b1);
        chk("ovf_count", count, 8);
        bm_en = 1'b1; bm_rand = 1'b0; bm_d = 1; bm_l = 3; bm_cnt = -1; tx_busy = 1'b0;
        ticks(80);
        chk("ovf_nbytes", got.size(), 8);
        for (int i = 0; i < 8; i++) chk("ovf_order", got[i], DW'(i + 1));
        chk("ovf_sticky", overflow, 1'b1);

        // ---- Wrap-around: 20 random bytes, 3-cycle Busy ----
        do_reset();
        bm_en = 1'b1; bm_d = 1; bm_l = 3; tx_busy = 1'b0;
        sent.delete();
        for (int i = 0; i < 400 && sent.size() < 20; i++) begin
            wr_en   = (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            wr_data = DW'($urandom);
            if (wr_en) sent.push_back(wr_data);
            tick();
        end
        wr_en = 1'b0;
        ticks(200);
        chk("wrap_nbytes", got.size(), 20);
        for (int i = 0; i < 20; i++) chk("wrap_order", got[i], sent[i]);
        chk("wrap_ov", overflow, 1'b0);

        // ---- Timeout: Busy never rises ----
        do_reset();
        bm_en = 1'b0; tx_busy = 1'b0;
        write(8'h3C);
        ticks(10);
        chk("to_gap",    t_lost - t_valid, 4);
        chk("to_first",  got[0], 8'h3C);
        bm_en = 1'b1; bm_d = 1; bm_l = 2; bm_cnt = -1;
        write(8'h5A);
        ticks(15);
        chk("to_nbytes", got.size(), 2);
        chk("to_next",   got[1], 8'h5A);
        chk("to_nlost",  lost_cnt, 1);

        // ---- Simultaneous write and pop at count = 3 ----
        do_reset();
        bm_en = 1'b0; tx_busy = 1'b1;
        b0 = DW'($urandom); b1 = DW'($urandom); b2 = DW'($urandom); bx = DW'($urandom);
        write(b0); write(b1); write(b2);
        chk("sim_count_pre", count, 3);
        bm_en = 1'b1; bm_d = 1; bm_l = 2; bm_cnt = -1; tx_busy = 1'b0;
        write(bx);
        chk("sim_count", count, 3);
        chk("sim_valid", tx_valid, 1'b1);
        ticks(60);
        chk("sim_nbytes", got.size(), 4);
        chk("sim_b0", got[0], b0);
        chk("sim_b1", got[1], b1);
        chk("sim_b2", got[2], b2);
        chk("sim_bx", got[3], bx);

        // ---- Reset in the middle of a frame ----
        do_reset();
        bm_en = 1'b0; tx_busy = 1'b0;
        write(DW'($urandom));
        tick();                 // launch edge
        tx_busy = 1'b1;
        ticks(2);               // transmitter now busy
        for (int i = 0; i < 5; i++) write(DW'($urandom));
        chk("mid_count_pre", count, 5);
        rst = 1'b1;
        tick();
        chk("mid_count", count, 0);
        chk("mid_empty", empty, 1'b1);
        chk("mid_ov",    overflow, 1'b0);
        chk("mid_valid", tx_valid, 1'b0);
        rst = 1'b0; tx_busy = 1'b0; got.delete();
        t_wr = cyc;
        write(8'hC3);
        ticks(4);
        chk("mid_relaunch_lat", t_valid - t_wr, 2);
        chk("mid_relaunch_n",   got.size(), 1);
        chk("mid_relaunch_d",   got[0], 8'hC3);

        // ---- Randomized soak ----
        do_reset();
        bm_en = 1'b1; bm_rand = 1'b1; bm_d = 1; bm_l = 2; tx_busy = 1'b0;
        for (int i = 0; i < 500; i++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_data = DW'($urandom);
            rst     = ($urandom_range(0, 149) == 0);
            if (rst) bm_cnt = -1;
            tick();
        end
        rst = 1'b0; wr_en = 1'b0;
        ticks(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
